// File: rtl/multicycle_control_if.sv
// Control/datapath bundle for the multicycle MIPS main control FSM.
// The master side is the control FSM; the slave side is the datapath and memory.
interface multicycle_control_if;
    logic [5:0]  opcode;
    logic        zero;
    logic        memReady;
    logic [1:0]  aluOp;
    logic        aluSrcA;
    logic [1:0]  aluSrcB;
    logic        memRead;
    logic        memWrite;
    logic        iorD;
    logic        irWrite;
    logic        pcWrite;
    logic [1:0]  pcSource;
    logic        regWrite;
    logic        regDst;
    logic        memToReg;
    logic        illegalOp;
    logic [3:0]  state;
    logic [31:0] retired;

    modport master (
        input  opcode, zero, memReady,
        output aluOp, aluSrcA, aluSrcB, memRead, memWrite, iorD, irWrite,
               pcWrite, pcSource, regWrite, regDst, memToReg, illegalOp,
               state, retired
    );

    modport slave (
        output opcode, zero, memReady,
        input  aluOp, aluSrcA, aluSrcB, memRead, memWrite, iorD, irWrite,
               pcWrite, pcSource, regWrite, regDst, memToReg, illegalOp,
               state, retired
    );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS core with retired-instruction counter.
// Define MULTICYCLE_JUMP_EN to compile in the JUMP state (opcode 0x02).
module multicycle_control (
    input logic clk,
    input logic reset,
    multicycle_control_if.master bus
);

    localparam logic [3:0] FETCH     = 4'd0;
    localparam logic [3:0] DECODE    = 4'd1;
    localparam logic [3:0] MEM_ADDR  = 4'd2;
    localparam logic [3:0] MEM_READ  = 4'd3;
    localparam logic [3:0] MEM_WB    = 4'd4;
    localparam logic [3:0] MEM_WRITE = 4'd5;
    localparam logic [3:0] EXEC_R    = 4'd6;
    localparam logic [3:0] R_WB      = 4'd7;
    localparam logic [3:0] EXEC_I    = 4'd8;
    localparam logic [3:0] I_WB      = 4'd9;
    localparam logic [3:0] BRANCH    = 4'd10;
`ifdef MULTICYCLE_JUMP_EN
    localparam logic [3:0] JUMP      = 4'd11;
`endif

    logic [3:0]  state;
    logic [3:0]  nextState;
    logic        retire;
    logic [31:0] retired;

    logic [1:0]  aluOp;
    logic        aluSrcA;
    logic [1:0]  aluSrcB;
    logic        memRead;
    logic        memWrite;
    logic        iorD;
    logic        irWrite;
    logic        pcWrite;
    logic [1:0]  pcSource;
    logic        regWrite;
    logic        regDst;
    logic        memToReg;
    logic        illegalOp;

    // Outputs stay at their zero defaults while reset is low, even though state reads FETCH.
    always_comb begin
        nextState = FETCH;
        retire    = 1'b0;
        aluOp     = 2'd0;
        aluSrcA   = 1'b0;
        aluSrcB   = 2'd0;
        memRead   = 1'b0;
        memWrite  = 1'b0;
        iorD      = 1'b0;
        irWrite   = 1'b0;
        pcWrite   = 1'b0;
        pcSource  = 2'd0;
        regWrite  = 1'b0;
        regDst    = 1'b0;
        memToReg  = 1'b0;
        illegalOp = 1'b0;
        if (reset) begin
            case (state)
                FETCH: begin
                    memRead = 1'b1;
                    aluSrcB = 2'd1;
                    aluOp   = 2'd2;
                    if (bus.memReady) begin
                        irWrite   = 1'b1;
                        pcWrite   = 1'b1;
                        nextState = DECODE;
                    end else begin
                        nextState = FETCH;
                    end
                end
                DECODE: begin
                    aluSrcB = 2'd3;
                    aluOp   = 2'd2;
                    case (bus.opcode)
                        6'h00:        nextState = EXEC_R;
                        6'h08:        nextState = EXEC_I;
                        6'h23, 6'h2B: nextState = MEM_ADDR;
                        6'h04, 6'h05: nextState = BRANCH;
`ifdef MULTICYCLE_JUMP_EN
                        6'h02:        nextState = JUMP;
`endif
                        default: begin
                            nextState = FETCH;
                            illegalOp = 1'b1;
                        end
                    endcase
                end
                MEM_ADDR: begin
                    aluSrcA   = 1'b1;
                    aluSrcB   = 2'd2;
                    aluOp     = 2'd2;
                    nextState = (bus.opcode == 6'h23) ? MEM_READ : MEM_WRITE;
                end
                MEM_READ: begin
                    memRead   = 1'b1;
                    iorD      = 1'b1;
                    nextState = bus.memReady ? MEM_WB : MEM_READ;
                end
                MEM_WB: begin
                    regWrite = 1'b1;
                    memToReg = 1'b1;
                    retire   = 1'b1;
                end
                MEM_WRITE: begin
                    memWrite  = 1'b1;
                    iorD      = 1'b1;
                    nextState = bus.memReady ? FETCH : MEM_WRITE;
                    retire    = bus.memReady;
                end
                EXEC_R: begin
                    aluSrcA   = 1'b1;
                    aluOp     = 2'd1;
                    nextState = R_WB;
                end
                R_WB: begin
                    regWrite = 1'b1;
                    regDst   = 1'b1;
                    retire   = 1'b1;
                end
                EXEC_I: begin
                    aluSrcA   = 1'b1;
                    aluSrcB   = 2'd2;
                    aluOp     = 2'd2;
                    nextState = I_WB;
                end
                I_WB: begin
                    regWrite = 1'b1;
                    retire   = 1'b1;
                end
                BRANCH: begin
                    aluSrcA  = 1'b1;
                    aluOp    = 2'd3;
                    pcSource = 2'd1;
                    pcWrite  = (bus.opcode == 6'h05) ? ~bus.zero : bus.zero;
                    retire   = 1'b1;
                end
`ifdef MULTICYCLE_JUMP_EN
                JUMP: begin
                    pcWrite  = 1'b1;
                    pcSource = 2'd2;
                    retire   = 1'b1;
                end
`endif
                default: nextState = FETCH;
            endcase
        end
    end

    // Every retiring state hands over to FETCH, so retire marks a completed instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= FETCH;
            retired <= 32'd0;
        end else begin
            state <= nextState;
            if (retire) begin
                retired <= retired + 32'd1;
            end
        end
    end

    assign bus.aluOp     = aluOp;
    assign bus.aluSrcA   = aluSrcA;
    assign bus.aluSrcB   = aluSrcB;
    assign bus.memRead   = memRead;
    assign bus.memWrite  = memWrite;
    assign bus.iorD      = iorD;
    assign bus.irWrite   = irWrite;
    assign bus.pcWrite   = pcWrite;
    assign bus.pcSource  = pcSource;
    assign bus.regWrite  = regWrite;
    assign bus.regDst    = regDst;
    assign bus.memToReg  = memToReg;
    assign bus.illegalOp = illegalOp;
    assign bus.state     = state;
    assign bus.retired   = retired;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle MIPS core: decodes the 6-bit opcode, sequences each instruction through fetch/decode/execute/memory/writeback, and drives the datapath enables. It is the producer of the 2-bit `aluOp` code that the ALU control decoder turns into `aluControl`. It also owns the memory request/ready handshake and keeps a retired-instruction count.

## Interface
- Parameters: none.
- `clk` in 1: core clock.
- `reset` in 1: asynchronous, active-low reset.
- `opcode` in 6: instruction[31:26], read from the instruction register.
- `zero` in 1: ALU zero flag.
- `memReady` in 1: memory completion for the current read or write.
- `aluOp` out 2: 0 = zero, 1 = R-type (func decode), 2 = ADD, 3 = SUB.
- `aluSrcA` out 1: 0 = PC, 1 = register A.
- `aluSrcB` out 2: 0 = register B, 1 = constant 4, 2 = sign-extended imm, 3 = sign-extended imm<<2.
- `memRead`, `memWrite` out 1 each: memory request, held until `memReady`.
- `iorD` out 1: memory address select, 0 = PC, 1 = ALUOut.
- `irWrite` out 1: instruction register load.
- `pcWrite` out 1: PC load, branch condition already resolved.
- `pcSource` out 2: 0 = ALU result, 1 = ALUOut (branch target), 2 = jump target.
- `regWrite`, `regDst`, `memToReg` out 1 each: register file write enable, rd/rt select, memory/ALU writeback select.
- `illegalOp` out 1: one-cycle pulse on an unknown opcode.
- `state` out 4: current state encoding, for debug.
- `retired` out 32: count of completed instructions.

## Operation
- State encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXEC_R=6, R_WB=7, EXEC_I=8, I_WB=9, BRANCH=10, JUMP=11. Codes 12–15 are unreachable and go to FETCH.
- **FETCH**
  - Drives `memRead`=1, `iorD`=0, `aluSrcA`=0, `aluSrcB`=1, `aluOp`=2, `pcSource`=0.
  - `irWrite` and `pcWrite` assert combinationally only in a cycle where `memReady`=1; the FSM then moves to DECODE. Otherwise it stays in FETCH.
- **DECODE**
  - Drives `aluSrcA`=0, `aluSrcB`=3, `aluOp`=2 to precompute the branch target.
  - Next state by opcode: 0x00 → EXEC_R; 0x08 → EXEC_I; 0x23 / 0x2B → MEM_ADDR; 0x04 / 0x05 → BRANCH; 0x02 → JUMP (see Configuration).
  - Any other opcode → FETCH with `illegalOp`=1. `retired` does not increment.
- **MEM_ADDR**: `aluSrcA`=1, `aluSrcB`=2, `aluOp`=2. Then MEM_READ for lw, MEM_WRITE for sw.
- **MEM_READ**: `memRead`=1, `iorD`=1. Waits for `memReady`, then MEM_WB.
- **MEM_WB**: `regWrite`=1, `regDst`=0, `memToReg`=1. Then FETCH.
- **MEM_WRITE**: `memWrite`=1, `iorD`=1. Waits for `memReady`, then FETCH.
- **EXEC_R**: `aluSrcA`=1, `aluSrcB`=0, `aluOp`=1. Then **R_WB**: `regWrite`=1, `regDst`=1, `memToReg`=0.
- **EXEC_I**: `aluSrcA`=1, `aluSrcB`=2, `aluOp`=2. Then **I_WB**: `regWrite`=1, `regDst`=0, `memToReg`=0.
- **BRANCH**
  - Drives `aluSrcA`=1, `aluSrcB`=0, `aluOp`=3, `pcSource`=1.
  - `pcWrite` = `zero` for beq (0x04) and `!zero` for bne (0x05).
- **JUMP**: `pcWrite`=1, `pcSource`=2.
- Every output not listed for a state is 0.
- `memReady` is ignored outside FETCH, MEM_READ and MEM_WRITE.
- `retired` increments by 1 on each transition into FETCH from MEM_WB, MEM_WRITE, R_WB, I_WB, BRANCH or JUMP. It wraps from 0xFFFFFFFF to 0.

## Timing
- State and `retired` are registered on the rising edge of `clk`. Outputs are decoded combinationally from state, `opcode`, `zero` and `memReady`.
- While `reset`=0, asynchronously:
  - `state` = FETCH and `retired` = 0;
  - every output is forced to 0, including `memRead`.
- After `reset` rises, the first edge evaluates FETCH normally.
- Cycles per instruction with `memReady` tied high: R-type 4, addi 4, lw 5, sw 4, beq/bne 3, j 3. Each memory wait cycle adds 1.
- Reset mid-instruction abandons the instruction: no further `regWrite`, `pcWrite` or `memWrite`, and no `retired` increment.

## Configuration
- `MULTICYCLE_JUMP_EN` defined: opcode 0x02 decodes to JUMP, as described above.
- Not defined:
  - The JUMP state is not compiled in, and `pcSource` never takes value 2.
  - Opcode 0x02 is treated as illegal: DECODE → FETCH with `illegalOp` pulsed.

## Test plan
- Reset held low with `memReady`=1 → all outputs 0, `state`=0, `retired`=0. Release → FETCH shows `memRead`=1 and `irWrite`=`pcWrite`=1 on the first edge.
- `opcode`=0x00, `memReady`=1 → states 0,1,6,7,0. `aluOp`=1 in EXEC_R; `regWrite`=`regDst`=1 in R_WB; `retired`=1 afterwards.
- `opcode`=0x23, `memReady` low for 3 cycles in MEM_READ → `memRead`=1, `iorD`=1 held for 4 cycles, then MEM_WB with `memToReg`=1. Total 8 cycles.
- `opcode`=0x04 with `zero`=1 → `pcWrite`=1, `pcSource`=1. `opcode`=0x05 with `zero`=1 → `pcWrite`=0 and `aluOp`=3.
- `opcode`=0x02 → JUMP with `pcSource`=2 when the macro is defined. Without the macro → `illegalOp` pulse, return to FETCH, `retired` unchanged.
- Reset asserted in MEM_WRITE while `memWrite`=1 → `memWrite` drops the same cycle, state returns to FETCH, and `retired` = 0.
